// File: rtl/pwl_decim_sampler_pkg.sv
// Shared types and quantizer for the PWL decimating sampler.
// The PWL net arrives as a fixed-point snapshot (value at the clock edge plus current slope).
package pwl_sampler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // known=0 stands for an unknown/NaN net value, which samples as 0 V.
  typedef struct packed {
    logic               known;
    logic signed [31:0] val_uv;
    logic signed [31:0] slope_uv_ns;
  } pwl_t;

  typedef struct packed {
    logic signed [31:0] code;
    logic               sat;
  } quant_t;

  // Value of the net dt_ps after the edge, extrapolated along the current segment.
  function automatic longint pwl_eval(input pwl_t p, input longint dt_ps);
    longint v;
    if (!p.known) begin
      v = 0;
    end else begin
      v = longint'(p.val_uv) + (longint'(p.slope_uv_ns) * dt_ps) / 1000;
    end
    return v;
  endfunction

  // Round half away from zero, then clip to the signed nbit range.
  function automatic quant_t quantize(input longint v_uv, input longint lsb_uv, input int nbit);
    longint mag;
    longint q;
    longint hi;
    longint lo;
    quant_t r;
    mag = (v_uv < 0) ? -v_uv : v_uv;
    q   = (2 * mag + lsb_uv) / (2 * lsb_uv);
    if (v_uv < 0) begin
      q = -q;
    end
    hi    = (longint'(1) << (nbit - 1)) - 1;
    lo    = -hi - 1;
    r.sat = 1'b0;
    if (q > hi) begin
      q     = hi;
      r.sat = 1'b1;
    end else if (q < lo) begin
      q     = lo;
      r.sat = 1'b1;
    end
    r.code = 32'(q);
    return r;
  endfunction

endpackage

// File: rtl/pwl_decim_sampler_if.sv
// Valid/ready result channel of the PWL decimating sampler.
interface pwl_decim_sampler_if #(
  parameter int NBIT = 8
);

  logic signed [NBIT-1:0] out_code;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_code,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_code,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/pwl_decim_sampler_skid.sv
// Two-entry valid/ready result buffer; a push into a full buffer without a pop is dropped.
module pwl_sampler_skid #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic signed [W-1:0] push_data,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  output logic                drop
);

  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic signed [W-1:0] head_q;
  logic signed [W-1:0] head_d;
  logic signed [W-1:0] tail_q;
  logic signed [W-1:0] tail_d;
  logic                pop;

  // A pop frees the head before the push lands, so push+pop on a full buffer never drops.
  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop    = 1'b0;
    case ({push, pop})
      2'b10: begin
        case (count_q)
          2'd0: begin
            head_d  = push_data;
            count_d = 2'd1;
          end
          2'd1: begin
            tail_d  = push_data;
            count_d = 2'd2;
          end
          default: drop = 1'b1;
        endcase
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (count_q != 2'd0);

endmodule

// File: rtl/pwl_decim_sampler.sv
// Samples a PWL net each clock, quantizes, block-averages 2**LOG2DEC codes, emits over valid/ready.
// Optional: PWL_SAMPLER_SLOPE_COMP_EN evaluates the net APERTURE seconds after the edge.
module pwl_decim_sampler
  import pwl_sampler_pkg::*;
#(
  parameter int  NBIT     = 8,
  parameter int  LOG2DEC  = 2,
  parameter real LSB      = 0.01,
  parameter real APERTURE = 0.0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pwl_t                       in,
  input  logic                       en,
  input  logic                       clr_flags,
  output logic                       sat,
  output logic                       overrun,
  pwl_decim_sampler_if.master        out_if
);

  localparam int     DEC     = 1 << LOG2DEC;
  localparam int     AW      = NBIT + LOG2DEC;
  localparam int     CW      = (LOG2DEC > 0) ? LOG2DEC : 1;
  localparam longint LSB_UV  = longint'(LSB * 1.0e6);
  localparam longint APER_PS = longint'(APERTURE * 1.0e12);
`ifdef PWL_SAMPLER_SLOPE_COMP_EN
  localparam bit     SLOPE_COMP = 1'b1;
`else
  localparam bit     SLOPE_COMP = 1'b0;
`endif
  localparam longint EVAL_DT_PS = SLOPE_COMP ? APER_PS : 64'sd0;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   acc_base;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   res_full;
  logic                   sat_q;
  logic                   sat_d;
  logic                   overrun_q;
  logic                   overrun_d;
  quant_t                 qr;
  logic signed [NBIT-1:0] sample_code;
  logic signed [NBIT-1:0] push_data;
  logic                   push;
  logic                   drop;
  logic                   last;

  // DEC codes of NBIT bits fit in AW bits, so the sum cannot wrap.
  always_comb begin
    qr          = quantize(pwl_eval(in, EVAL_DT_PS), LSB_UV, NBIT);
    sample_code = qr.code[NBIT-1:0];
    acc_base    = (state_q == ACC) ? acc_q : '0;
    sum         = acc_base + AW'(sample_code);
    res_full    = sum >>> LOG2DEC;
    push_data   = res_full[NBIT-1:0];
    last        = (state_q == IDLE) ? (DEC == 1) : (cnt_q == CW'(DEC - 1));
  end

  // Dropping en abandons the partial block; the first enabled edge is already sample 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    push    = 1'b0;
    case (state_q)
      IDLE:    if (en) state_d = ACC;
      ACC:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (en) begin
      if (last) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = ((state_q == ACC) ? cnt_q : '0) + 1'b1;
      end
    end else begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // A new event on the same edge as clr_flags keeps the flag set.
  always_comb begin
    sat_d     = (sat_q & ~clr_flags) | (en & qr.sat);
    overrun_d = (overrun_q & ~clr_flags) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  pwl_sampler_skid #(
    .W(NBIT)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_ready (out_if.out_ready),
    .out_data  (out_if.out_code),
    .out_valid (out_if.out_valid),
    .drop      (drop)
  );

  assign sat     = sat_q;
  assign overrun = overrun_q;

endmodule
